// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  // Destination of a read response travelling through the owner pipeline
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Deepest supported memory latency; the owner pipeline is sized for it
  localparam int MAX_LAT      = 4;
  localparam int DEF_MEM_LAT  = 1;
  localparam int DEF_MAX_WAIT = 4;

  // Owner tag recorded for a grant: I reads, D reads, or nothing (write / idle)
  function automatic owner_e owner_on_grant(input logic i_gnt,
                                            input logic d_gnt,
                                            input logic d_is_read);
    owner_e own;
    if (i_gnt) begin
      own = OWN_I;
    end else if (d_gnt && d_is_read) begin
      own = OWN_D;
    end else begin
      own = OWN_NONE;
    end
    return own;
  endfunction

  // A flush turns any fetch tag into NONE and leaves data tags untouched
  function automatic owner_e flush_owner(input owner_e own, input logic flush);
    owner_e res;
    if (flush && (own == OWN_I)) begin
      res = OWN_NONE;
    end else begin
      res = own;
    end
    return res;
  endfunction

endpackage

// File: rtl/arb_resp_tracker.sv
// Owner pipeline: remembers which port each issued read belongs to so the
// returning memory data can be steered, with fetch tags removable on flush.
module arb_resp_tracker
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic   clk,
  input  logic   rst,
  input  owner_e load_own,
  input  logic   flush,
  output owner_e resp_owner
);

  // Out-of-range latencies are pulled into the supported window
  localparam int LAT_C = (MEM_LAT < 1) ? 1 : ((MEM_LAT > MAX_LAT) ? MAX_LAT : MEM_LAT);

  owner_e slot_r [MAX_LAT+1];

  // Advance every tag one slot per cycle; a flush scrubs fetch tags in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= MAX_LAT; k++) begin
        slot_r[k] <= OWN_NONE;
      end
    end else begin
      slot_r[0] <= flush_owner(load_own, flush);
      for (int k = 1; k <= MAX_LAT; k++) begin
        slot_r[k] <= flush_owner(slot_r[k-1], flush);
      end
    end
  end

  // The slot aligned with valid memory data names the destination; a flush
  // in that same cycle also hides a fetch response
  always_comb begin
    resp_owner = flush_owner(slot_r[LAT_C], flush);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch port (I) and
// the load/store port (D). D normally wins; a wait counter forces a fetch
// through after MAX_WAIT refusals. Commands are registered, read data is
// steered back by the owner pipeline after the fixed memory latency.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = DEF_MEM_LAT,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_flush,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_cs,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  // Out-of-range wait limits are pulled into the 1..15 window of the counter
  localparam int         WAIT_C     = (MAX_WAIT < 1) ? 1 : ((MAX_WAIT > 15) ? 15 : MAX_WAIT);
  localparam logic [3:0] WAIT_MAX_C = 4'(WAIT_C);

  logic       i_gnt_s;
  logic       d_gnt_s;
  logic       d_is_read_s;
  logic [3:0] wait_cnt_r;
  owner_e     load_own_s;
  owner_e     resp_owner_s;

  // Pick at most one requester: D by default, I once it has waited long enough
  always_comb begin
    i_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (rst) begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else if (i_req && d_req) begin
      if (wait_cnt_r == WAIT_MAX_C) begin
        i_gnt_s = 1'b1;
      end else begin
        d_gnt_s = 1'b1;
      end
    end else if (i_req) begin
      i_gnt_s = 1'b1;
    end else if (d_req) begin
      d_gnt_s = 1'b1;
    end else begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end
  end

  assign i_gnt = i_gnt_s;
  assign d_gnt = d_gnt_s;

  // Count cycles a pending fetch is refused, saturating at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= 4'd0;
    end else if (!i_req || i_gnt_s) begin
      wait_cnt_r <= 4'd0;
    end else if (wait_cnt_r != WAIT_MAX_C) begin
      wait_cnt_r <= wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Register the granted command toward memory; address and data hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cs    <= 1'b0;
      mem_we    <= {STRB_W{1'b0}};
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
    end else if (d_gnt_s) begin
      mem_cs    <= 1'b1;
      mem_we    <= d_we;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
    end else if (i_gnt_s) begin
      mem_cs    <= 1'b1;
      mem_we    <= {STRB_W{1'b0}};
      mem_addr  <= i_addr;
      mem_wdata <= mem_wdata;
    end else begin
      mem_cs    <= 1'b0;
      mem_we    <= {STRB_W{1'b0}};
      mem_addr  <= mem_addr;
      mem_wdata <= mem_wdata;
    end
  end

  // Tag each grant with the port expecting data; writes complete at grant
  always_comb begin
    d_is_read_s = (d_we == {STRB_W{1'b0}});
    load_own_s  = owner_on_grant(i_gnt_s, d_gnt_s, d_is_read_s);
  end

  arb_resp_tracker #(
    .MEM_LAT (MEM_LAT)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .load_own   (load_own_s),
    .flush      (i_flush),
    .resp_owner (resp_owner_s)
  );

  // Memory data goes to both ports; only the owning port sees rvalid
  always_comb begin
    i_rdata  = mem_rdata;
    d_rdata  = mem_rdata;
    i_rvalid = (resp_owner_s == OWN_I);
    d_rvalid = (resp_owner_s == OWN_D);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: one arbiter with MEM_LAT=1 (A) and one with MEM_LAT=3 (B).
// Stimulus pushes hand-computed expected commands/responses with the cycle
// they must appear in; monitors pop and compare when the DUT presents them.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; logic [31:0] data; } rsp_t;
  typedef struct { int cyc; logic [3:0] we; logic [31:0] addr; logic [31:0] wdata; } cmd_t;

  rsp_t a_iq[$];
  rsp_t a_dq[$];
  rsp_t b_iq[$];
  rsp_t b_dq[$];
  cmd_t a_cq[$];

  // DUT A signals
  logic        a_i_req, a_i_flush, a_i_gnt, a_i_rvalid;
  logic [31:0] a_i_addr, a_i_rdata;
  logic        a_d_req, a_d_gnt, a_d_rvalid;
  logic [3:0]  a_d_we;
  logic [31:0] a_d_addr, a_d_wdata, a_d_rdata;
  logic        a_mem_cs;
  logic [3:0]  a_mem_we;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  // DUT B signals
  logic        b_i_req, b_i_flush, b_i_gnt, b_i_rvalid;
  logic [31:0] b_i_addr, b_i_rdata;
  logic        b_d_req, b_d_gnt, b_d_rvalid;
  logic [3:0]  b_d_we;
  logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
  logic        b_mem_cs;
  logic [3:0]  b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_WAIT(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_flush(a_i_flush), .i_gnt(a_i_gnt),
    .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_cs(a_mem_cs), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_WAIT(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_flush(b_i_flush), .i_gnt(b_i_gnt),
    .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_cs(b_mem_cs), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Memory contents: one known instruction, everything else address-derived
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0050_0093;
    else return {a[15:0], ~a[15:0]};
  endfunction

  // Memory models: data valid MEM_LAT cycles after mem_cs, junk otherwise
  logic [31:0] a_pipe;
  logic [31:0] b_pipe [3];
  always @(posedge clk) begin
    a_pipe    <= a_mem_cs ? rom(a_mem_addr) : 32'hBAD0_BAD0;
    b_pipe[0] <= b_mem_cs ? rom(b_mem_addr) : 32'hBAD0_BAD0;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign a_mem_rdata = a_pipe;
  assign b_mem_rdata = b_pipe[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor A: responses and memory commands
  always @(negedge clk) begin : mon_a
    rsp_t r;
    cmd_t c;
    if (a_i_rvalid) begin
      if (a_iq.size() == 0) chk("a_i_rvalid_unexpected", {31'b0, a_i_rvalid}, 32'd0);
      else begin
        r = a_iq.pop_front();
        chk("a_i_rvalid_cycle", cyc, r.cyc);
        chk("a_i_rdata", a_i_rdata, r.data);
      end
    end
    if (a_d_rvalid) begin
      if (a_dq.size() == 0) chk("a_d_rvalid_unexpected", {31'b0, a_d_rvalid}, 32'd0);
      else begin
        r = a_dq.pop_front();
        chk("a_d_rvalid_cycle", cyc, r.cyc);
        chk("a_d_rdata", a_d_rdata, r.data);
      end
    end
    if (a_mem_cs) begin
      if (a_cq.size() == 0) chk("a_mem_cs_unexpected", {31'b0, a_mem_cs}, 32'd0);
      else begin
        c = a_cq.pop_front();
        chk("a_mem_cs_cycle", cyc, c.cyc);
        chk("a_mem_we", {28'b0, a_mem_we}, {28'b0, c.we});
        chk("a_mem_addr", a_mem_addr, c.addr);
        if (c.we != 4'b0) chk("a_mem_wdata", a_mem_wdata, c.wdata);
      end
    end
  end

  // Monitor B: responses; every B command is a read with zero write data
  always @(negedge clk) begin : mon_b
    rsp_t r;
    if (b_i_rvalid) begin
      if (b_iq.size() == 0) chk("b_i_rvalid_unexpected", {31'b0, b_i_rvalid}, 32'd0);
      else begin
        r = b_iq.pop_front();
        chk("b_i_rvalid_cycle", cyc, r.cyc);
        chk("b_i_rdata", b_i_rdata, r.data);
      end
    end
    if (b_d_rvalid) begin
      if (b_dq.size() == 0) chk("b_d_rvalid_unexpected", {31'b0, b_d_rvalid}, 32'd0);
      else begin
        r = b_dq.pop_front();
        chk("b_d_rvalid_cycle", cyc, r.cyc);
        chk("b_d_rdata", b_d_rdata, r.data);
      end
    end
    if (b_mem_cs) begin
      chk("b_mem_we", {28'b0, b_mem_we}, 32'd0);
      chk("b_mem_wdata", b_mem_wdata, 32'd0);
    end
  end

  // One cycle on A: drive, check grants, push expectations from expected grants
  task automatic step_a(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic [3:0] dwe, input logic [31:0] da, input logic [31:0] dwd,
                        input logic eg_i, input logic eg_d, input logic track);
    @(posedge clk); #1;
    a_i_req = ir; a_i_addr = ia; a_d_req = dr; a_d_we = dwe; a_d_addr = da; a_d_wdata = dwd;
    @(negedge clk);
    chk("a_i_gnt", {31'b0, a_i_gnt}, {31'b0, eg_i});
    chk("a_d_gnt", {31'b0, a_d_gnt}, {31'b0, eg_d});
    if (track) begin
      if (eg_i) begin
        a_cq.push_back('{cyc + 1, 4'b0000, ia, 32'h0});
        a_iq.push_back('{cyc + 2, rom(ia)});
      end else if (eg_d) begin
        a_cq.push_back('{cyc + 1, dwe, da, dwd});
        if (dwe == 4'b0000) a_dq.push_back('{cyc + 2, rom(da)});
      end
    end
  endtask

  task automatic idle_a(input int n);
    for (int k = 0; k < n; k++) step_a(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  // One cycle on B (reads only, latency 3)
  task automatic step_b(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic [31:0] da, input logic fl,
                        input logic eg_i, input logic eg_d, input logic push);
    @(posedge clk); #1;
    b_i_req = ir; b_i_addr = ia; b_d_req = dr; b_d_addr = da; b_i_flush = fl;
    @(negedge clk);
    chk("b_i_gnt", {31'b0, b_i_gnt}, {31'b0, eg_i});
    chk("b_d_gnt", {31'b0, b_d_gnt}, {31'b0, eg_d});
    if (push && eg_i) b_iq.push_back('{cyc + 4, rom(ia)});
    if (push && eg_d) b_dq.push_back('{cyc + 4, rom(da)});
  endtask

  task automatic idle_b(input int n);
    for (int k = 0; k < n; k++) step_b(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_a_quiet(input string tag);
    chk({tag, "_i_gnt"}, {31'b0, a_i_gnt}, 32'd0);
    chk({tag, "_d_gnt"}, {31'b0, a_d_gnt}, 32'd0);
    chk({tag, "_mem_cs"}, {31'b0, a_mem_cs}, 32'd0);
    chk({tag, "_mem_we"}, {28'b0, a_mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, a_mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, a_mem_wdata, 32'd0);
    chk({tag, "_i_rvalid"}, {31'b0, a_i_rvalid}, 32'd0);
    chk({tag, "_d_rvalid"}, {31'b0, a_d_rvalid}, 32'd0);
  endtask

  initial begin
    a_i_req = 1'b0; a_i_addr = 32'h0; a_i_flush = 1'b0;
    a_d_req = 1'b0; a_d_we = 4'h0; a_d_addr = 32'h0; a_d_wdata = 32'h0;
    b_i_req = 1'b0; b_i_addr = 32'h0; b_i_flush = 1'b0;
    b_d_req = 1'b0; b_d_we = 4'h0; b_d_addr = 32'h0; b_d_wdata = 32'h0;

    // Reset state: requests present but nothing granted or issued
    rst = 1'b1;
    a_i_req = 1'b1; a_d_req = 1'b1; a_d_we = 4'hF; a_d_addr = 32'h55; a_d_wdata = 32'h1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_a_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    a_i_req = 1'b0; a_d_req = 1'b0; a_d_we = 4'h0; a_d_addr = 32'h0; a_d_wdata = 32'h0;
    idle_a(2);

    // Single fetch at 0x10: grant t0, command t1, data t2
    step_a(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle_a(3);

    // Both request: D first, I next cycle
    step_a(1'b1, 32'h40, 1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 1'b1, 1'b1);
    step_a(1'b1, 32'h40, 1'b0, 4'h0, 32'h0,   32'h0, 1'b1, 1'b0, 1'b1);
    idle_a(3);

    // Starvation guard: D wins four times, I forced at t4, D resumes at t5
    step_a(1'b1, 32'h100, 1'b1, 4'h0, 32'h300, 32'h0, 1'b0, 1'b1, 1'b1);
    step_a(1'b1, 32'h100, 1'b1, 4'h0, 32'h304, 32'h0, 1'b0, 1'b1, 1'b1);
    step_a(1'b1, 32'h100, 1'b1, 4'h0, 32'h308, 32'h0, 1'b0, 1'b1, 1'b1);
    step_a(1'b1, 32'h100, 1'b1, 4'h0, 32'h30C, 32'h0, 1'b0, 1'b1, 1'b1);
    step_a(1'b1, 32'h100, 1'b1, 4'h0, 32'h310, 32'h0, 1'b1, 1'b0, 1'b1);
    step_a(1'b0, 32'h0,   1'b1, 4'h0, 32'h310, 32'h0, 1'b0, 1'b1, 1'b1);
    idle_a(3);

    // Byte-lane write: strobes/address/data forwarded, never an rvalid
    step_a(1'b0, 32'h0, 1'b1, 4'b0100, 32'h23, 32'h00AB_0000, 1'b0, 1'b1, 1'b1);
    idle_a(3);

    // Reset during back-to-back fetches: in-flight reads vanish
    step_a(1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    a_cq.push_back('{cyc + 1, 4'b0000, 32'h0, 32'h0});
    step_a(1'b1, 32'h4, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; a_i_addr = 32'h8;
    @(negedge clk);
    chk_a_quiet("midrst");
    @(posedge clk); #1;
    rst = 1'b0; a_i_req = 1'b0; a_i_addr = 32'h0;
    @(negedge clk);
    idle_a(5);
    step_a(1'b1, 32'h44, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle_a(3);

    // B, latency 3: flush kills the I read in flight, D read still returns at t5
    step_b(1'b1, 32'h80, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0);
    step_b(1'b0, 32'h0,  1'b1, 32'h84, 1'b0, 1'b0, 1'b1, 1'b1);
    step_b(1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0);
    idle_b(5);

    // Flush in the very cycle the fetch data arrives
    step_b(1'b1, 32'h90, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_b(3);
    step_b(1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_b(2);

    // Fetch granted during a flush is dropped; the next one returns normally
    step_b(1'b1, 32'hA0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    step_b(1'b1, 32'hA4, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_b(6);

    // Every expected command and response must have been seen
    chk("a_iq_left", a_iq.size(), 32'd0);
    chk("a_dq_left", a_dq.size(), 32'd0);
    chk("a_cq_left", a_cq.size(), 32'd0);
    chk("b_iq_left", b_iq.size(), 32'd0);
    chk("b_dq_left", b_dq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
